// File: rtl/icache_pkg.sv
// Shared constants for the instruction cache: logic levels, bus width,
// default index/tag geometry and a small address helper.
package icache_pkg;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;
    localparam logic HIGH  = 1'b1;
    localparam logic LOW   = 1'b0;

    localparam int DATA_BUS_W        = 32;
    localparam int ICACHE_INDEX_BITS = 8;
    localparam int ICACHE_TAG_BITS   = DATA_BUS_W - ICACHE_INDEX_BITS - 2;

    // Word-align a byte address (instruction fetches are always whole words).
    function automatic logic [DATA_BUS_W-1:0] align_addr(input logic [DATA_BUS_W-1:0] addr);
        return {addr[DATA_BUS_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/icache_array.sv
// Line storage for the direct-mapped instruction cache: one valid bit, tag and
// 32-bit data word per line. Reads are combinational on rd_index; writes are
// synchronous. Only the valid bits are reset, tag/data contents are don't-care
// until their line is filled.
module icache_array
    import icache_pkg::*;
#(
    parameter int INDEX_BITS = ICACHE_INDEX_BITS,
    parameter int TAG_BITS   = ICACHE_TAG_BITS,
    parameter int DATA_W     = DATA_BUS_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INDEX_BITS-1:0] rd_index,
    output logic                  rd_valid,
    output logic [TAG_BITS-1:0]   rd_tag,
    output logic [DATA_W-1:0]     rd_data,
    input  logic                  wr_en,
    input  logic [INDEX_BITS-1:0] wr_index,
    input  logic [TAG_BITS-1:0]   wr_tag,
    input  logic [DATA_W-1:0]     wr_data
);

    localparam int LINES = 1 << INDEX_BITS;

    logic [LINES-1:0]    valid_r;
    logic [TAG_BITS-1:0] tag_mem_r  [LINES];
    logic [DATA_W-1:0]   data_mem_r [LINES];

    // Valid bits: cleared by reset, set when a line is filled.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r <= '0;
        end else if (wr_en) begin
            valid_r[wr_index] <= 1'b1;
        end
    end

    // Tag and data storage: written on fill, overwriting whatever was there.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem_r[wr_index]  <= wr_tag;
            data_mem_r[wr_index] <= wr_data;
        end
    end

    assign rd_valid = valid_r[rd_index];
    assign rd_tag   = tag_mem_r[rd_index];
    assign rd_data  = data_mem_r[rd_index];

endmodule

// File: rtl/icache.sv
// Direct-mapped instruction cache between the fetch unit and the memory
// controller. Hits answer one cycle after the request; misses issue a single
// word read, fill the line and then answer. A fetch-side clear during a miss
// lets the memory read complete (the line is still filled) but suppresses the
// response to the fetcher.
module icache
    import icache_pkg::*;
#(
    parameter int INDEX_BITS = ICACHE_INDEX_BITS,
    parameter int TAG_BITS   = ICACHE_TAG_BITS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        IF_rn,
    input  logic [31:0] IF_addr,
    input  logic        IF_clear,
    output logic        IF_ready,
    output logic [31:0] IF_inst,
    output logic        MC_rn,
    output logic [31:0] MC_addr,
    input  logic        MC_ready,
    input  logic [31:0] MC_value
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_MISS = 1'b1;

    logic [0:0]            state_r;
    logic                  abort_r;
    logic                  gap_r;
    logic                  if_ready_r;
    logic [31:0]           if_inst_r;
    logic                  mc_rn_r;
    logic [31:0]           mc_addr_r;
    logic [INDEX_BITS-1:0] fill_index_r;
    logic [TAG_BITS-1:0]   fill_tag_r;

    logic [INDEX_BITS-1:0] req_index_s;
    logic [TAG_BITS-1:0]   req_tag_s;
    logic                  line_valid_s;
    logic [TAG_BITS-1:0]   line_tag_s;
    logic [31:0]           line_data_s;
    logic                  hit_s;
    logic                  accept_s;
    logic                  fill_we_s;
    logic                  unused_addr_s;

    assign req_index_s   = IF_addr[INDEX_BITS+1:2];
    assign req_tag_s     = IF_addr[31:INDEX_BITS+2];
    assign unused_addr_s = ^IF_addr[1:0];

    icache_array #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_BITS   (TAG_BITS),
        .DATA_W     (DATA_BUS_W)
    ) u_array (
        .clk      (clk),
        .rst      (rst),
        .rd_index (req_index_s),
        .rd_valid (line_valid_s),
        .rd_tag   (line_tag_s),
        .rd_data  (line_data_s),
        .wr_en    (fill_we_s),
        .wr_index (fill_index_r),
        .wr_tag   (fill_tag_r),
        .wr_data  (MC_value)
    );

    // Lookup, acceptance and fill-enable decode for the current cycle.
    always_comb begin
        hit_s     = 1'b0;
        accept_s  = 1'b0;
        fill_we_s = 1'b0;
        if (line_valid_s && (line_tag_s == req_tag_s)) begin
            hit_s = 1'b1;
        end else begin
            hit_s = 1'b0;
        end
        // No new request is taken while a response is being presented.
        if (IF_rn && !IF_clear && !if_ready_r) begin
            accept_s = 1'b1;
        end else begin
            accept_s = 1'b0;
        end
        // The fill is tied to the same edge that captures MC_ready.
        if (!rst && rdy && (state_r == ST_MISS) && MC_ready) begin
            fill_we_s = 1'b1;
        end else begin
            fill_we_s = 1'b0;
        end
    end

    // Control FSM and registered fetch/memory-side outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            abort_r      <= 1'b0;
            gap_r        <= 1'b0;
            if_ready_r   <= 1'b0;
            if_inst_r    <= 32'h0000_0000;
            mc_rn_r      <= 1'b0;
            mc_addr_r    <= 32'h0000_0000;
            fill_index_r <= '0;
            fill_tag_r   <= '0;
        end else if (rdy) begin
            if_ready_r <= 1'b0;
            gap_r      <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        if (hit_s) begin
                            if_ready_r <= 1'b1;
                            if_inst_r  <= line_data_s;
                        end else if (!gap_r) begin
                            // gap_r keeps MC_rn low for a second cycle after an
                            // aborted fill, where no response pulse holds off
                            // the next request.
                            mc_rn_r      <= 1'b1;
                            mc_addr_r    <= align_addr(IF_addr);
                            fill_index_r <= req_index_s;
                            fill_tag_r   <= req_tag_s;
                            abort_r      <= 1'b0;
                            state_r      <= ST_MISS;
                        end
                    end
                end
                ST_MISS: begin
                    if (MC_ready) begin
                        mc_rn_r <= 1'b0;
                        gap_r   <= 1'b1;
                        state_r <= ST_IDLE;
                        abort_r <= 1'b0;
                        if (!abort_r && !IF_clear) begin
                            if_ready_r <= 1'b1;
                            if_inst_r  <= MC_value;
                        end
                    end else if (IF_clear) begin
                        abort_r <= 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    mc_rn_r <= 1'b0;
                    abort_r <= 1'b0;
                end
            endcase
        end
    end

    assign IF_ready = if_ready_r;
    assign IF_inst  = if_inst_r;
    assign MC_rn    = mc_rn_r;
    assign MC_addr  = mc_addr_r;

endmodule
